xor_arbiter: RTL and testbench

XOR_ARBITER -- requirements
Module: xor_arbiter

---
 rtl/xor_arbiter_pkg.sv | 18 +
 rtl/xor_unit.sv | 20 ++
 rtl/xor_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_xor_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// xor_arbiter_pkg
// Shared definitions for the XOR arbiter slice:
//   - default requester count and operand width
//   - FSM state encoding (IDLE / EXEC / RESP)
// ---------------------------------------------------------------------------
package xor_arbiter_pkg;

    localparam int unsigned XOR_ARB_N_REQ_DEFAULT = 32'd4;
    localparam int unsigned XOR_ARB_WIDTH_DEFAULT = 32'd8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/xor_unit.sv
// ---------------------------------------------------------------------------
// xor_unit
// Shared combinational datapath of the arbiter: y = a ^ b.
// Ports:
//   a, b : WIDTH-bit operands
//   y    : WIDTH-bit result
// ---------------------------------------------------------------------------
module xor_unit
    import xor_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = XOR_ARB_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_arbiter.sv
// ---------------------------------------------------------------------------
// xor_arbiter
// Round-robin arbiter in front of a single shared XOR unit. One transaction
// is in flight at a time: IDLE (arbitrate/accept) -> EXEC (compute, one
// cycle) -> RESP (hold result until rsp_ready).
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-requester request valid            [N_REQ]
//   req_a      : operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      : operand B, same packing as req_a
//   req_ready  : one-hot accept strobe (IDLE only)      [N_REQ]
//   rsp_valid  : result valid (RESP)
//   rsp_ready  : consumer ready
//   rsp_id     : index of the served requester
//   rsp_y      : A ^ B of the served requester
//   rsp_par    : even-parity bit of rsp_y
//
// Configuration:
//   XOR_ARBITER_PARITY_EN - when defined, rsp_par is the registered
//   reduction XOR of rsp_y; otherwise rsp_par is tied to 0.
// ---------------------------------------------------------------------------
module xor_arbiter
    import xor_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = XOR_ARB_N_REQ_DEFAULT,
    parameter int unsigned WIDTH = XOR_ARB_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]           rsp_y,
    output logic                       rsp_par
);

    localparam int unsigned     ID_W    = $clog2(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 32'd1);

    arb_state_e       state_r;
    arb_state_e       state_nxt_s;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [ID_W-1:0]  id_r;
    logic [ID_W-1:0]  winner_id_s;
    logic             winner_found_s;
    logic             accept_s;
    logic             complete_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] xor_y_s;
    logic [WIDTH-1:0] rsp_y_r;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        logic [ID_W-1:0] idx_v;
        idx_v          = {ID_W{1'b0}};
        winner_found_s = 1'b0;
        winner_id_s    = {ID_W{1'b0}};
        for (int unsigned k = 32'd0; k < N_REQ; k++) begin
            idx_v = ID_W'((32'(rr_ptr_r) + k) % N_REQ);
            if (!winner_found_s && req_valid[idx_v]) begin
                winner_found_s = 1'b1;
                winner_id_s    = idx_v;
            end else begin
                winner_found_s = winner_found_s;
            end
        end
    end

    assign accept_s   = (state_r == IDLE) && winner_found_s;
    assign complete_s = (state_r == RESP) && rsp_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (winner_found_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs; req_ready is gated by rst_n so it stays low during reset.
    always_comb begin
        req_ready = {N_REQ{1'b0}};
        rsp_valid = 1'b0;
        if (rst_n && accept_s) begin
            req_ready[winner_id_s] = 1'b1;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
        if (state_r == RESP) begin
            rsp_valid = 1'b1;
        end else begin
            rsp_valid = 1'b0;
        end
    end

    // Operand/index capture at accept and round-robin pointer advance at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            id_r     <= {ID_W{1'b0}};
            rr_ptr_r <= {ID_W{1'b0}};
        end else begin
            if (accept_s) begin
                a_r  <= req_a[32'(winner_id_s) * WIDTH +: WIDTH];
                b_r  <= req_b[32'(winner_id_s) * WIDTH +: WIDTH];
                id_r <= winner_id_s;
            end
            if (complete_s) begin
                // The served requester is searched last next time.
                rr_ptr_r <= (id_r == LAST_ID) ? {ID_W{1'b0}} : id_r + 1'b1;
            end
        end
    end

    xor_unit #(
        .WIDTH (WIDTH)
    ) u_xor_unit (
        .a (a_r),
        .b (b_r),
        .y (xor_y_s)
    );

    // Result register, loaded during the single EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_y_r <= {WIDTH{1'b0}};
        end else if (state_r == EXEC) begin
            rsp_y_r <= xor_y_s;
        end else begin
            rsp_y_r <= rsp_y_r;
        end
    end

    assign rsp_id = id_r;
    assign rsp_y  = rsp_y_r;

`ifdef XOR_ARBITER_PARITY_EN
    logic rsp_par_r;

    function automatic logic even_parity(input logic [WIDTH-1:0] data);
        return ^data;
    endfunction

    // Parity register, loaded alongside rsp_y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_par_r <= 1'b0;
        end else if (state_r == EXEC) begin
            rsp_par_r <= even_parity(xor_y_s);
        end else begin
            rsp_par_r <= rsp_par_r;
        end
    end

    assign rsp_par = rsp_par_r;
`else
    assign rsp_par = 1'b0;
`endif

endmodule

// File: tb/tb_xor_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xor_arbiter
// Self-checking bench for xor_arbiter. A 4x8 instance covers arbitration,
// latency, backpressure and reset; a 2x2 instance covers all 2-bit operand
// pairs. Expected values come from a round-robin reference model kept here.
// ---------------------------------------------------------------------------
module tb_xor_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_y;
    logic           rsp_par;

    logic [1:0]     s_req_valid;
    logic [3:0]     s_req_a;
    logic [3:0]     s_req_b;
    logic [1:0]     s_req_ready;
    logic           s_rsp_valid;
    logic           s_rsp_ready;
    logic [0:0]     s_rsp_id;
    logic [1:0]     s_rsp_y;
    logic           s_rsp_par;

    int          errors = 0;
    int          checks = 0;
    int          m_ptr  = 0;
    int unsigned cyc    = 0;

    xor_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_par(rsp_par)
    );

    xor_arbiter #(.N_REQ(2), .WIDTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_a(s_req_a), .req_b(s_req_b),
        .req_ready(s_req_ready), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_id(s_rsp_id), .rsp_y(s_rsp_y), .rsp_par(s_rsp_par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: first valid index at or above ptr, wrapping.
    function automatic int model_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic model_par(input logic [W-1:0] y);
`ifdef XOR_ARBITER_PARITY_EN
        return ($countones(y) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1; req_a = $urandom; req_b = $urandom;
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_y !== 8'h00) begin errors++; $display("FAIL reset_rsp_y: got %0h want 0", rsp_y); end
        checks++; if (rsp_par !== 1'b0) begin errors++; $display("FAIL reset_rsp_par: got %0b want 0", rsp_par); end
        step;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        req_valid = 4'h0; rst_n = 1'b1; m_ptr = 0;
        step;
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0; #2; rst_n = 1'b1; m_ptr = 0;
        step;
    endtask

    task automatic test_single;
        req_a = $urandom; req_b = $urandom;
        req_a[23:16] = 8'hF0; req_b[23:16] = 8'h3C;
        req_valid = 4'b0100; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        step; req_valid = 4'b0000;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_exec: got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_exec: got %0b want 0", rsp_valid); end
        step;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", rsp_id); end
        checks++; if (rsp_y !== 8'hCC) begin errors++; $display("FAIL single_y: got %0h want cc", rsp_y); end
        checks++; if (rsp_par !== model_par(8'hCC)) begin errors++; $display("FAIL single_par: got %0b want %0b", rsp_par, model_par(8'hCC)); end
        step;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_done: got %0b want 0", rsp_valid); end
        m_ptr = 3;
    endtask

    task automatic test_wrap;
        int w;
        logic [W-1:0] exp_y;
        for (int t = 0; t < 2; t++) begin
            req_valid = 4'b0011; req_a = $urandom; req_b = $urandom; rsp_ready = 1'b1;
            w = model_winner(req_valid, m_ptr);
            exp_y = req_a[w*W +: W] ^ req_b[w*W +: W];
            #1;
            checks++; if (req_ready !== 4'(1 << w)) begin errors++; $display("FAIL wrap_grant%0d: got %b want %b", t, req_ready, 4'(1 << w)); end
            step; step;
            checks++; if (rsp_id !== 2'(w)) begin errors++; $display("FAIL wrap_id%0d: got %0d want %0d", t, rsp_id, w); end
            checks++; if (rsp_y !== exp_y) begin errors++; $display("FAIL wrap_y%0d: got %0h want %0h", t, rsp_y, exp_y); end
            step;
            m_ptr = (w + 1) % N;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_round_robin;
        int exp_w;
        int waited;
        int unsigned last_cyc;
        pulse_reset;
        last_cyc = 0;
        req_valid = 4'hF; rsp_ready = 1'b1; req_a = $urandom; req_b = $urandom;
        #1;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            while (req_ready === 4'b0000 && waited < 8) begin step; waited++; end
            checks++; if (waited >= 8) begin errors++; $display("FAIL rr_timeout%0d: got no grant want grant within 8 cycles", g); end
            exp_w = model_winner(4'hF, m_ptr);
            checks++; if (req_ready !== 4'(1 << exp_w)) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, 4'(1 << exp_w)); end
            if (g > 0) begin
                checks++; if (cyc - last_cyc != 3) begin errors++; $display("FAIL rr_spacing%0d: got %0d want 3", g, cyc - last_cyc); end
            end
            last_cyc = cyc;
            m_ptr = (exp_w + 1) % N;
            step;
        end
        req_valid = 4'b0000;
        step; step;
    endtask

    task automatic test_backpressure;
        int w;
        int nxt;
        logic [W-1:0] exp_y;
        req_valid = 4'hF; rsp_ready = 1'b0; req_a = $urandom; req_b = $urandom;
        w = model_winner(req_valid, m_ptr);
        exp_y = req_a[w*W +: W] ^ req_b[w*W +: W];
        #1;
        checks++; if (req_ready !== 4'(1 << w)) begin errors++; $display("FAIL bp_grant: got %b want %b", req_ready, 4'(1 << w)); end
        step; step;
        for (int s = 0; s < 5; s++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %0b want 1", s, rsp_valid); end
            checks++; if (rsp_id !== 2'(w)) begin errors++; $display("FAIL bp_id%0d: got %0d want %0d", s, rsp_id, w); end
            checks++; if (rsp_y !== exp_y) begin errors++; $display("FAIL bp_y%0d: got %0h want %0h", s, rsp_y, exp_y); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d: got %b want 0000", s, req_ready); end
            step;
        end
        rsp_ready = 1'b1;
        step;
        m_ptr = (w + 1) % N;
        nxt = model_winner(4'hF, m_ptr);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_complete: got %0b want 0", rsp_valid); end
        checks++; if (req_ready !== 4'(1 << nxt)) begin errors++; $display("FAIL bp_next_grant: got %b want %b", req_ready, 4'(1 << nxt)); end
        req_valid = 4'b0000; rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_random;
        int w;
        int stall;
        logic [N-1:0] v;
        logic [W-1:0] exp_y;
        for (int t = 0; t < 24; t++) begin
            v = 4'($urandom_range(1, 15));
            req_valid = v; req_a = $urandom; req_b = $urandom; rsp_ready = 1'b0;
            w = model_winner(v, m_ptr);
            exp_y = req_a[w*W +: W] ^ req_b[w*W +: W];
            #1;
            checks++; if (req_ready !== 4'(1 << w)) begin errors++; $display("FAIL rand_grant%0d: got %b want %b", t, req_ready, 4'(1 << w)); end
            step;
            // New operands after accept must not reach the result.
            req_valid = 4'($urandom); req_a = $urandom; req_b = $urandom;
            step;
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                checks++; if (rsp_y !== exp_y) begin errors++; $display("FAIL rand_hold%0d: got %0h want %0h", t, rsp_y, exp_y); end
                step;
            end
            rsp_ready = 1'b1;
            #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rand_valid%0d: got %0b want 1", t, rsp_valid); end
            checks++; if (rsp_id !== 2'(w)) begin errors++; $display("FAIL rand_id%0d: got %0d want %0d", t, rsp_id, w); end
            checks++; if (rsp_y !== exp_y) begin errors++; $display("FAIL rand_y%0d: got %0h want %0h", t, rsp_y, exp_y); end
            checks++; if (rsp_par !== model_par(exp_y)) begin errors++; $display("FAIL rand_par%0d: got %0b want %0b", t, rsp_par, model_par(exp_y)); end
            step;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rand_done%0d: got %0b want 0", t, rsp_valid); end
            req_valid = 4'b0000; rsp_ready = 1'b0;
            m_ptr = (w + 1) % N;
            #1;
        end
    endtask

    task automatic test_reset_mid;
        // Abort in EXEC.
        req_valid = 4'b1000; req_a = $urandom; req_b = $urandom; rsp_ready = 1'b1;
        #1;
        step; req_valid = 4'b0000;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_valid: got %0b want 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_exec_ready: got %b want 0000", req_ready); end
        step; rst_n = 1'b1; m_ptr = 0;
        for (int s = 0; s < 4; s++) begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_no_rsp%0d: got %0b want 0", s, rsp_valid); end
            step;
        end
        // Pointer is back at 0 after reset.
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'(1 << model_winner(4'hF, m_ptr))) begin errors++; $display("FAIL rst_ptr: got %b want %b", req_ready, 4'(1 << model_winner(4'hF, m_ptr))); end
        // Abort in RESP.
        req_valid = 4'b0010; rsp_ready = 1'b0;
        #1;
        step; req_valid = 4'b0000;
        step;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_resp_pre: got %0b want 1", rsp_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %0b want 0", rsp_valid); end
        checks++; if (rsp_y !== 8'h00) begin errors++; $display("FAIL rst_resp_y: got %0h want 0", rsp_y); end
        step; rst_n = 1'b1; m_ptr = 0;
        step;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_no_rsp: got %0b want 0", rsp_valid); end
    endtask

    task automatic test_exhaustive;
        int r;
        s_rsp_ready = 1'b1;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                r = $urandom_range(0, 1);
                s_req_a = 4'($urandom); s_req_b = 4'($urandom);
                s_req_a[r*2 +: 2] = 2'(a); s_req_b[r*2 +: 2] = 2'(b);
                s_req_valid = 2'(1 << r);
                #1;
                step; s_req_valid = 2'b00;
                step;
                checks++; if (s_rsp_valid !== 1'b1) begin errors++; $display("FAIL exh_valid_%0d_%0d: got %0b want 1", a, b, s_rsp_valid); end
                checks++; if (s_rsp_id !== 1'(r)) begin errors++; $display("FAIL exh_id_%0d_%0d: got %0d want %0d", a, b, s_rsp_id, r); end
                checks++; if (s_rsp_y !== 2'(a ^ b)) begin errors++; $display("FAIL exh_y_%0d_%0d: got %0d want %0d", a, b, s_rsp_y, a ^ b); end
                step;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid = 4'h0; req_a = '0; req_b = '0; rsp_ready = 1'b0; rst_n = 1'b1;
        s_req_valid = 2'b00; s_req_a = 4'h0; s_req_b = 4'h0; s_rsp_ready = 1'b0;
        test_reset;
        test_single;
        test_wrap;
        test_round_robin;
        test_backpressure;
        test_random;
        test_reset_mid;
        test_exhaustive;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
